mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around mem_arbiter.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter for the shared memory port: LSU priority, IFU starvation
// guard, response routing to the owning requester and a WAIT-state timeout error.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_lsu_q, owner_lsu_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [63:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;

  logic promote, in_idle, in_wait;
  logic ifu_grant, lsu_grant;
  logic timeout_hit, resp_ok, resp_to, resp_fire;

  assign promote   = (starve_q == SW'(STARVE_LIMIT));
  assign in_idle   = (state_q == IDLE);
  assign in_wait   = (state_q == WAIT);

  // Readies are gated by rst_n so they read 0 while reset is held.
  assign bus.ifu_req_ready = rst_n & in_idle & (~bus.lsu_req_valid | promote);
  assign bus.lsu_req_ready = rst_n & in_idle & ~(promote & bus.ifu_req_valid);

  assign ifu_grant = bus.ifu_req_valid & bus.ifu_req_ready;
  assign lsu_grant = bus.lsu_req_valid & bus.lsu_req_ready;

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
  assign resp_ok     = in_wait & bus.mem_resp_valid;
  assign resp_to     = in_wait & ~bus.mem_resp_valid & timeout_hit;
  assign resp_fire   = resp_ok | resp_to;

  assign bus.ifu_resp_valid = resp_fire & ~owner_lsu_q;
  assign bus.ifu_resp_err   = resp_to & ~owner_lsu_q;
  assign bus.ifu_rdata      = (resp_ok & ~owner_lsu_q) ? bus.mem_rdata : '0;
  assign bus.lsu_resp_valid = resp_fire & owner_lsu_q;
  assign bus.lsu_resp_err   = resp_to & owner_lsu_q;
  assign bus.lsu_rdata      = (resp_ok & owner_lsu_q) ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    timer_d     = timer_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_grant) begin
          state_d     = REQ;
          owner_lsu_d = 1'b1;
          addr_d      = bus.lsu_addr;
          wen_d       = bus.lsu_wen;
          wdata_d     = bus.lsu_wdata;
          wmask_d     = bus.lsu_wmask;
          if (bus.ifu_req_valid && !promote) starve_d = starve_q + SW'(1);
        end else if (ifu_grant) begin
          state_d     = REQ;
          owner_lsu_d = 1'b0;
          addr_d      = bus.ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          starve_d    = '0;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (resp_fire) state_d = IDLE;
        else           timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      timer_q     <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      timer_q     <= timer_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// starvation, timeout-adjacent and reset sequences.
module tb_mem_arbiter;
  localparam logic [63:0] IA = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LA = 64'h0000_0000_0000_1000;
  localparam logic [63:0] WD = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] D0 = 64'h0000_0013_0000_0297;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        ifu_v, lsu_v, wen, mrr, mrv;
    logic [63:0] mrd;
    logic        ifu_rdy, lsu_rdy, mreqv, mwen;
    logic [63:0] maddr;
    logic        ifu_rv, ifu_err;
    logic [63:0] ifu_rd;
    logic        lsu_rv, lsu_err;
    logic [63:0] lsu_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic iv, logic lv, logic w, logic rr, logic rv,
                              logic [63:0] rd, logic irdy, logic lrdy, logic mq, logic mw,
                              logic [63:0] ma, logic irv, logic ierr, logic [63:0] ird,
                              logic lrv, logic lerr, logic [63:0] lrd);
    vec_t v;
    v.name = nm; v.ifu_v = iv; v.lsu_v = lv; v.wen = w; v.mrr = rr; v.mrv = rv; v.mrd = rd;
    v.ifu_rdy = irdy; v.lsu_rdy = lrdy; v.mreqv = mq; v.mwen = mw; v.maddr = ma;
    v.ifu_rv = irv; v.ifu_err = ierr; v.ifu_rd = ird;
    v.lsu_rv = lrv; v.lsu_err = lerr; v.lsu_rd = lrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic lv, input logic w, input logic rr,
                       input logic rv, input logic [63:0] rd);
    bus.ifu_req_valid  = iv;
    bus.lsu_req_valid  = lv;
    bus.lsu_wen        = w;
    bus.mem_req_ready  = rr;
    bus.mem_resp_valid = rv;
    bus.mem_rdata      = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus_req(input string nm, input logic lsu_owner, input logic w);
    chk({nm, ".mreqv"}, 64'(bus.mem_req_valid), 64'd1);
    chk({nm, ".maddr"}, bus.mem_addr, lsu_owner ? LA : IA);
    chk({nm, ".mwen"},  64'(bus.mem_wen), 64'(w));
    chk({nm, ".mwdata"}, bus.mem_wdata, lsu_owner ? WD : 64'd0);
    chk({nm, ".mwmask"}, 64'(bus.mem_wmask), lsu_owner ? 64'hFF : 64'd0);
  endtask

  task automatic apply(input vec_t v);
    drive(v.ifu_v, v.lsu_v, v.wen, v.mrr, v.mrv, v.mrd);
    #4;
    n_vec++;
    chk({v.name, ".ifu_rdy"}, 64'(bus.ifu_req_ready), 64'(v.ifu_rdy));
    chk({v.name, ".lsu_rdy"}, 64'(bus.lsu_req_ready), 64'(v.lsu_rdy));
    chk({v.name, ".mreqv"},   64'(bus.mem_req_valid), 64'(v.mreqv));
    chk({v.name, ".ifu_rv"},  64'(bus.ifu_resp_valid), 64'(v.ifu_rv));
    chk({v.name, ".ifu_err"}, 64'(bus.ifu_resp_err), 64'(v.ifu_err));
    chk({v.name, ".ifu_rd"},  bus.ifu_rdata, v.ifu_rd);
    chk({v.name, ".lsu_rv"},  64'(bus.lsu_resp_valid), 64'(v.lsu_rv));
    chk({v.name, ".lsu_err"}, 64'(bus.lsu_resp_err), 64'(v.lsu_err));
    chk({v.name, ".lsu_rd"},  bus.lsu_rdata, v.lsu_rd);
    if (v.mreqv) chk_bus_req(v.name, v.maddr == LA, v.mwen);
    next_cycle();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ifu_rdy"}, 64'(bus.ifu_req_ready), 64'd0);
    chk({nm, ".lsu_rdy"}, 64'(bus.lsu_req_ready), 64'd0);
    chk({nm, ".mreqv"},   64'(bus.mem_req_valid), 64'd0);
    chk({nm, ".ifu_rv"},  64'(bus.ifu_resp_valid), 64'd0);
    chk({nm, ".lsu_rv"},  64'(bus.lsu_resp_valid), 64'd0);
    chk({nm, ".ifu_err"}, 64'(bus.ifu_resp_err), 64'd0);
    chk({nm, ".lsu_err"}, 64'(bus.lsu_resp_err), 64'd0);
    chk({nm, ".ifu_rd"},  bus.ifu_rdata, 64'd0);
    chk({nm, ".lsu_rd"},  bus.lsu_rdata, 64'd0);
    chk({nm, ".maddr"},   bus.mem_addr, 64'd0);
    chk({nm, ".mwen"},    64'(bus.mem_wen), 64'd0);
    chk({nm, ".mwdata"},  bus.mem_wdata, 64'd0);
    chk({nm, ".mwmask"},  64'(bus.mem_wmask), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ifu_win;
    bus.ifu_addr  = IA;
    bus.lsu_addr  = LA;
    bus.lsu_wdata = WD;
    bus.lsu_wmask = 8'hFF;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    // IFU single fetch, LSU store, stalled LSU load, IFU timeout then a late response.
    tbl.push_back(mk("ifu_acc", 1,0,0,0,0,0,     1,1,0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(mk("ifu_req", 0,0,0,1,0,0,     0,0,1,0,IA, 0,0,0, 0,0,0));
    tbl.push_back(mk("ifu_rsp", 0,0,0,0,1,D0,    0,0,0,0,0,  1,0,D0, 0,0,0));
    tbl.push_back(mk("st_acc",  0,1,1,0,0,0,     0,1,0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(mk("st_req",  0,0,1,1,0,0,     0,0,1,1,LA, 0,0,0, 0,0,0));
    tbl.push_back(mk("st_rsp",  0,0,0,0,1,64'h55, 0,0,0,0,0, 0,0,0, 1,0,64'h55));
    tbl.push_back(mk("ld_acc",  0,1,0,0,0,0,     0,1,0,0,0,  0,0,0, 0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("ld_stall", 1,1,0,0,1,64'h77, 0,0,1,0,LA, 0,0,0, 0,0,0));
    tbl.push_back(mk("ld_go",   0,0,0,1,0,0,     0,0,1,0,LA, 0,0,0, 0,0,0));
    tbl.push_back(mk("ld_rsp",  0,0,0,0,1,64'hA5A5, 0,0,0,0,0, 0,0,0, 1,0,64'hA5A5));
    tbl.push_back(mk("to_acc",  1,0,0,0,0,0,     1,1,0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(mk("to_req",  0,0,0,1,0,0,     0,0,1,0,IA, 0,0,0, 0,0,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk("to_wait", 0,0,0,0,0,64'h1234, 0,0,0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("to_err",  0,0,0,0,0,64'h1234, 0,0,0,0,0, 1,1,0, 0,0,0));
    tbl.push_back(mk("late_rsp", 0,0,0,0,1,64'h1234, 1,1,0,0,0, 0,0,0, 0,0,0));

    #3;
    n_vec++;
    chk_all_zero("reset");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    foreach (tbl[i]) apply(tbl[i]);

    // Both requesters always valid: LSU x4 then IFU, repeated.
    for (int t = 0; t < 10; t++) begin
      ifu_win = ((t % 5) == 4);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
      #4;
      n_vec++;
      chk($sformatf("starve%0d.ifu_rdy", t), 64'(bus.ifu_req_ready), 64'(ifu_win));
      chk($sformatf("starve%0d.lsu_rdy", t), 64'(bus.lsu_req_ready), 64'(!ifu_win));
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
      #4;
      n_vec++;
      chk_bus_req($sformatf("starve%0d", t), !ifu_win, !ifu_win);
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h100 + 64'(t));
      #4;
      n_vec++;
      chk($sformatf("starve%0d.ifu_rv", t), 64'(bus.ifu_resp_valid), 64'(ifu_win));
      chk($sformatf("starve%0d.lsu_rv", t), 64'(bus.lsu_resp_valid), 64'(!ifu_win));
      chk($sformatf("starve%0d.rd", t), ifu_win ? bus.ifu_rdata : bus.lsu_rdata, 64'h100 + 64'(t));
      next_cycle();
    end

    // LSU load abandoned by reset during WAIT.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hBAD);
    #1;
    n_vec++;
    chk({"wait_pre_rst", ".lsu_rv"}, 64'(bus.lsu_resp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk_all_zero("rst_async");
    next_cycle();
    n_vec++;
    chk_all_zero("rst_held");

    // Release with both valid and a stray response: LSU wins, stray response ignored.
    rst_n = 1'b1;
    #3;
    n_vec++;
    chk("rel.ifu_rdy", 64'(bus.ifu_req_ready), 64'd0);
    chk("rel.lsu_rdy", 64'(bus.lsu_req_ready), 64'd1);
    chk("rel.lsu_rv",  64'(bus.lsu_resp_valid), 64'd0);
    chk("rel.ifu_rv",  64'(bus.ifu_resp_valid), 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hBAD);
    #3;
    n_vec++;
    chk_bus_req("rel_req", 1'b1, 1'b0);
    chk("rel_req.lsu_rv", 64'(bus.lsu_resp_valid), 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h600D);
    #3;
    n_vec++;
    chk("rel_rsp.lsu_rv", 64'(bus.lsu_resp_valid), 64'd1);
    chk("rel_rsp.lsu_rd", bus.lsu_rdata, 64'h600D);
    chk("rel_rsp.ifu_rv", 64'(bus.ifu_resp_valid), 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
